// File: rtl/fpu_addsub_pkg.sv
// Shared constants for the Add-Subt datapath.
// The optional subtract path is enabled by defining CSA_SUB_EN; it is left undefined by default.
package fpu_addsub_pkg;

    localparam int CSA_W_DEFAULT = 32;

    // Three W-bit operands sum to at most 3*(2^W-1), so two extra bits suffice.
    function automatic int csa_out_w(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational row of 3:2 compressor cells: per-bit XOR sum and majority carry.
module csa_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] maj
);

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        assign maj[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

endmodule

// File: rtl/csa3_add_pipe.sv
// Two-stage three-operand adder (3:2 compress, then carry-propagate) with valid/ready backpressure.
// Define CSA_SUB_EN to add the op_sub_i port and compute A+B-C.
module csa3_add_pipe
    import fpu_addsub_pkg::*;
#(
    parameter  int W     = CSA_W_DEFAULT,
    localparam int OUT_W = csa_out_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     c_i,
`ifdef CSA_SUB_EN
    input  logic             op_sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] result_o
);

    logic           s1_valid;
    logic [W-1:0]   sum_r;
    logic [W:0]     car_r;
    logic [W-1:0]   c_eff;
    logic [W-1:0]   sum_c;
    logic [W-1:0]   maj_c;
    logic           cin;
    logic           s2_adv;
    logic           accept;
    logic [OUT_W-1:0] fix;

`ifdef CSA_SUB_EN
    logic sub_r;
    // ~C is only W bits wide; the correction sign-extends it into the two top result bits.
    localparam logic [OUT_W-1:0] SUB_FIX = {2'b11, {W{1'b0}}};

    assign c_eff = op_sub_i ? ~c_i : c_i;
    assign cin   = op_sub_i;
    assign fix   = sub_r ? SUB_FIX : '0;
`else
    assign c_eff = c_i;
    assign cin   = 1'b0;
    assign fix   = '0;
`endif

    assign s2_adv     = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || s2_adv;
    assign accept     = in_valid_i && in_ready_o;

    csa_row #(.W(W)) u_row (
        .a   (a_i),
        .b   (b_i),
        .c   (c_eff),
        .sum (sum_c),
        .maj (maj_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            sum_r       <= '0;
            car_r       <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                sum_r    <= sum_c;
                car_r    <= {maj_c, cin};
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                out_valid_o <= s1_valid;
                // Keep the last result visible while the output stage is empty.
                if (s1_valid)
                    result_o <= OUT_W'(sum_r) + OUT_W'(car_r) + fix;
            end
        end
    end

`ifdef CSA_SUB_EN
    always_ff @(posedge clk) begin
        if (rst)
            sub_r <= 1'b0;
        else if (accept)
            sub_r <= op_sub_i;
    end
`endif

endmodule

// File: tb/tb_csa3_add_pipe.sv
// Directed bench for csa3_add_pipe at W=8: vector table, streaming, backpressure, reset mid-flight.
module tb_csa3_add_pipe;

    localparam int W     = 8;
    localparam int OUT_W = 10;

    typedef struct {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [W-1:0]     c;
        logic             sub;
        logic [OUT_W-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             out_ready_i = 1'b1;
    logic [W-1:0]     a_i = '0;
    logic [W-1:0]     b_i = '0;
    logic [W-1:0]     c_i = '0;
    logic             op_sub_i = 1'b0;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [OUT_W-1:0] result_o;

    csa3_add_pipe #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .c_i         (c_i),
`ifdef CSA_SUB_EN
        .op_sub_i    (op_sub_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Values are stable at the falling edge; a handshake seen here completes at the next rise.
    logic [OUT_W-1:0] got[$];
    int               got_cyc[$];
    always @(negedge clk)
        if (!rst && out_valid_o && out_ready_i) begin
            got.push_back(result_o);
            got_cyc.push_back(cyc);
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        a_i        = v.a;
        b_i        = v.b;
        c_i        = v.c;
        op_sub_i   = v.sub;
        in_valid_i = 1'b1;
    endtask

    // Single transaction into an empty pipe: result must appear exactly two edges after accept.
    task automatic run_row(input vec_t v, input string nm);
        drive(v);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1_valid"}, 32'(out_valid_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(out_valid_o), 32'd1);
        chk({nm, "_result"}, 32'(result_o), 32'(v.exp));
    endtask

    vec_t tbl[6];
    vec_t strm[16];
    vec_t bp[3];

    initial begin
        tbl[0] = '{8'd3,   8'd5,   8'd7,   1'b0, 10'd15};
        tbl[1] = '{8'hFF,  8'hFF,  8'hFF,  1'b0, 10'h2FD};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   1'b0, 10'd0};
        tbl[3] = '{8'h80,  8'h80,  8'h80,  1'b0, 10'd384};
        tbl[4] = '{8'd1,   8'hFF,  8'd0,   1'b0, 10'd256};
        tbl[5] = '{8'hAA,  8'h55,  8'hFF,  1'b0, 10'd510};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_result",    32'(result_o),    32'd0);
        chk("rst_in_ready",  32'(in_ready_o),  32'd1);

        // Directed table
        for (int i = 0; i < 6; i++)
            run_row(tbl[i], $sformatf("tbl%0d", i));

        // Streaming, 16 back-to-back
        for (int i = 0; i < 16; i++) begin
            strm[i].a   = W'($urandom_range(0, 255));
            strm[i].b   = W'($urandom_range(0, 255));
            strm[i].c   = W'($urandom_range(0, 255));
            strm[i].sub = 1'b0;
            strm[i].exp = OUT_W'(strm[i].a) + OUT_W'(strm[i].b) + OUT_W'(strm[i].c);
        end
        @(posedge clk);
        got.delete();
        got_cyc.delete();
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(strm[i]);
            @(negedge clk);
            chk($sformatf("strm_in_ready%0d", i), 32'(in_ready_o), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("strm_count", 32'(got.size()), 32'd16);
        if (got.size() == 16)
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("strm_res%0d", i), 32'(got[i]), 32'(strm[i].exp));
                chk($sformatf("strm_cyc%0d", i), 32'(got_cyc[i] - got_cyc[0]), 32'(i));
            end

        // Backpressure: three sends, output held for 5 clocks
        bp[0] = '{8'd10,  8'd20,  8'd30,  1'b0, 10'd60};
        bp[1] = '{8'd100, 8'd200, 8'd255, 1'b0, 10'd555};
        bp[2] = '{8'd1,   8'd2,   8'd4,   1'b0, 10'd7};
        got.delete();
        got_cyc.delete();
        out_ready_i = 1'b0;
        drive(bp[0]);
        drive(bp[1]);
        @(negedge clk);
        chk("bp_in_ready_2nd", 32'(in_ready_o), 32'd1);
        drive(bp[2]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid_o), 32'd1);
            chk($sformatf("bp_hold_res%0d", k),   32'(result_o),    32'(bp[0].exp));
            chk($sformatf("bp_hold_rdy%0d", k),   32'(in_ready_o),  32'd0);
            @(posedge clk);
        end
        #1;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3)
            for (int i = 0; i < 3; i++)
                chk($sformatf("bp_res%0d", i), 32'(got[i]), 32'(bp[i].exp));

        // Reset with both stages full
        got.delete();
        got_cyc.delete();
        out_ready_i = 1'b0;
        drive(bp[1]);
        drive(bp[2]);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("rmf_full_valid", 32'(out_valid_o), 32'd1);
        chk("rmf_full_rdy",   32'(in_ready_o),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("rmf_out_valid", 32'(out_valid_o), 32'd0);
        chk("rmf_result",    32'(result_o),    32'd0);
        chk("rmf_in_ready",  32'(in_ready_o),  32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rmf_no_stale", 32'(got.size()), 32'd0);

`ifdef CSA_SUB_EN
        run_row('{8'd2,   8'd1,   8'd10, 1'b1, 10'h3F9}, "sub_neg7");
        run_row('{8'd200, 8'd100, 8'd50, 1'b1, 10'd250}, "sub_250");
        run_row('{8'd200, 8'd100, 8'd50, 1'b0, 10'd350}, "add_350");
        run_row('{8'd0,   8'd0,   8'd0,  1'b1, 10'd0},   "sub_zero");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
